cc_miss_hit_sequencer: RTL and testbench
========================================

// Module: cc_miss_hit_sequencer
// PURPOSE
// - Sequences lookup results into the data reorder unit and the memory AR channel, keeping the two in program order.
// - Hit: pushes flag=1 to the hit flag FIFO and {offset, line} to the hit data FIFO.
// - Miss: pushes flag=0 to the hit flag FIFO and issues one 8-beat AXI read burst to memory (critical word first).
// - Sits between the tag-lookup stage and the data reorder unit; it is the only writer of both reorder FIFOs.
// PARAMETERS
// - ADDR_W   32  request/AR address width
// - HDATA_W  518 hit data width: {offset[5:0], line[511:0]}
// - MAX_OUTS 2   maximum misses accepted whose R burst has not completed (>=1)
// PORTS
// - clk                   in   1        clock
// - rst_n                 in   1        asynchronous active-low reset
// - lookup_valid_i        in   1        lookup result valid
// - lookup_ready_o        out  1        result accepted when valid&ready
// - lookup_hit_i          in   1        1=hit, 0=miss
// - lookup_addr_i         in   ADDR_W   request byte address
// - lookup_hdata_i        in   HDATA_W  hit line plus offset (don't-care on miss)
// - hit_flag_fifo_afull_i in   1        flag FIFO almost full
// - hit_flag_fifo_wren_o  out  1        flag FIFO write
// - hit_flag_fifo_wdata_o out  1        flag = lookup_hit_i
// - hit_data_fifo_afull_i in   1        data FIFO almost full
// - hit_data_fifo_wren_o  out  1        data FIFO write
// - hit_data_fifo_wdata_o out  HDATA_W  = lookup_hdata_i
// - mem_araddr_o          out  ADDR_W   {addr[ADDR_W-1:3], 3'b0}
// - mem_arlen_o           out  4        constant 4'd7
// - mem_arsize_o          out  3        constant 3'd3 (8 B)
// - mem_arburst_o         out  2        constant 2'b10 (WRAP)
// - mem_arvalid_o         out  1        AR valid
// - mem_arready_i         in   1        AR ready
// - mem_rvalid_i          in   1        snooped memory R valid
// - mem_rready_i          in   1        snooped R ready (driven by reorder unit)
// - mem_rlast_i           in   1        snooped R last
// - busy_o                out  1        state!=S_IDLE or outs_cnt!=0
// BEHAVIOUR
// - Reset (async): state=S_IDLE, mem_arvalid_o=0, mem_araddr_o=0, outs_cnt=0; all wren=0, lookup_ready_o=0, busy_o=0.
// - States S_IDLE and S_AR.
// - lookup_ready_o = (state==S_IDLE) & !hit_flag_fifo_afull_i & (lookup_hit_i ? !hit_data_fifo_afull_i : outs_cnt<MAX_OUTS).
// - Accept = lookup_valid_i & lookup_ready_o. FIFO writes are combinational in the accept cycle (0 latency).
// - Hit accept: hit_flag_fifo_wren_o=1 with wdata=1, hit_data_fifo_wren_o=1. State stays S_IDLE.
// - Miss accept: flag wren=1 with wdata=0; araddr registered; outs_cnt+1; go to S_AR.
// - S_AR: mem_arvalid_o=1 from the cycle after accept. araddr stays stable until arready.
//   - On arvalid&arready, go to S_IDLE (arvalid=0 next cycle). No new lookup is accepted while in S_AR.
// - R completion = mem_rvalid_i & mem_rready_i & mem_rlast_i; it decrements outs_cnt.
//   - Accept and completion in the same cycle: outs_cnt unchanged.
//   - Completion with outs_cnt==0: protocol error; the counter saturates at 0 (assertion in bench).
// - outs_cnt width is $clog2(MAX_OUTS+1). At outs_cnt==MAX_OUTS a miss stalls (ready=0); hits still flow.
// - afull on either FIFO drops ready the same cycle. Data-FIFO afull blocks hits only.
// - Flag order equals accept order, which matches AXI in-order R return, so the reorder mux stays aligned.
// - Reset mid-burst drops pending AR and counter; the FIFOs and memory are reset by the same rst_n.
// STRUCTURE
// - cc_pkg: state enum {S_IDLE,S_AR}, CC_ARLEN=4'd7, CC_ARSIZE=3'd3, CC_ARBURST_WRAP=2'b10, CC_LINE_W=512.
// - No sub-module: one FSM register, one AR address register, one outstanding counter, combinational accept.
// TESTING
// - Hit, FIFOs not afull, addr=0x1000 -> flag wren wdata=1 and data wren in the same cycle; arvalid stays 0.
// - Miss addr=0x2034 -> flag wdata=0 same cycle; next cycle arvalid=1, araddr=0x2030, arlen=7, arburst=2'b10.
//   - Hold arready=0 for 3 cycles -> araddr stable; ready=0 until handshake.
// - MAX_OUTS=2: 3 misses with no R completion -> 3rd stalls (ready=0); a hit then proceeds.
//   - Rlast completion -> 3rd miss accepted the next cycle.
// - Miss accept and rlast completion in the same cycle with outs_cnt=1 -> outs_cnt stays 1.
// - hit_data_fifo_afull_i=1 with hit pending -> ready=0, no wren; a miss with afull=1 is still accepted.
// - Assert rst_n low while in S_AR with outs_cnt=2 -> arvalid=0, busy_o=0 immediately (async).

Source files
------------

// File: rtl/cc_miss_hit_sequencer_pkg.sv
// Shared types and constants for the miss/hit sequencer.
//   cc_state_e      : sequencer FSM states
//   CC_ARLEN/SIZE   : fixed AXI burst shape for a line fill (8 beats of 8 bytes)
//   CC_ARBURST_WRAP : wrapping burst so the critical word returns first
//   CC_HDATA_W      : width of the hit payload {offset, line}
package cc_miss_hit_sequencer_pkg;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_AR   = 1'b1
   } cc_state_e;

   localparam logic [3:0] CC_ARLEN        = 4'd7;
   localparam logic [2:0] CC_ARSIZE       = 3'd3;
   localparam logic [1:0] CC_ARBURST_WRAP = 2'b10;

   localparam int unsigned CC_LINE_W   = 512;
   localparam int unsigned CC_OFFSET_W = 6;
   localparam int unsigned CC_HDATA_W  = CC_LINE_W + CC_OFFSET_W;

endpackage

// File: rtl/cc_miss_hit_sequencer_if.sv
// Bus bundle around the miss/hit sequencer.
//   lookup_*        : lookup result from the tag stage (valid/ready)
//   hit_flag_fifo_* : flag FIFO write port (1=hit, 0=miss)
//   hit_data_fifo_* : hit data FIFO write port ({offset, line})
//   mem_ar*         : AXI read address channel towards memory
//   mem_r*          : snooped R channel handshake, used only to count completions
//   busy_o          : sequencer has work in flight
// The slave modport is the sequencer's view; master is the surrounding environment.
interface cc_miss_hit_sequencer_if
   import cc_miss_hit_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned HDATA_W = CC_HDATA_W
);

   logic               lookup_valid_i;
   logic               lookup_ready_o;
   logic               lookup_hit_i;
   logic [ADDR_W-1:0]  lookup_addr_i;
   logic [HDATA_W-1:0] lookup_hdata_i;

   logic               hit_flag_fifo_afull_i;
   logic               hit_flag_fifo_wren_o;
   logic               hit_flag_fifo_wdata_o;

   logic               hit_data_fifo_afull_i;
   logic               hit_data_fifo_wren_o;
   logic [HDATA_W-1:0] hit_data_fifo_wdata_o;

   logic [ADDR_W-1:0]  mem_araddr_o;
   logic [3:0]         mem_arlen_o;
   logic [2:0]         mem_arsize_o;
   logic [1:0]         mem_arburst_o;
   logic               mem_arvalid_o;
   logic               mem_arready_i;

   logic               mem_rvalid_i;
   logic               mem_rready_i;
   logic               mem_rlast_i;

   logic               busy_o;

   modport slave (
      input  lookup_valid_i, lookup_hit_i, lookup_addr_i, lookup_hdata_i,
      output lookup_ready_o,
      input  hit_flag_fifo_afull_i,
      output hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
      input  hit_data_fifo_afull_i,
      output hit_data_fifo_wren_o, hit_data_fifo_wdata_o,
      output mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o, mem_arvalid_o,
      input  mem_arready_i,
      input  mem_rvalid_i, mem_rready_i, mem_rlast_i,
      output busy_o
   );

   modport master (
      output lookup_valid_i, lookup_hit_i, lookup_addr_i, lookup_hdata_i,
      input  lookup_ready_o,
      output hit_flag_fifo_afull_i,
      input  hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
      output hit_data_fifo_afull_i,
      input  hit_data_fifo_wren_o, hit_data_fifo_wdata_o,
      input  mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o, mem_arvalid_o,
      output mem_arready_i,
      output mem_rvalid_i, mem_rready_i, mem_rlast_i,
      input  busy_o
   );

endinterface

// File: rtl/cc_miss_hit_sequencer.sv
// Miss/hit sequencer: routes lookup results into the reorder FIFOs and the memory AR
// channel while keeping program order.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : lookup input, flag/data FIFO write ports, AR channel, snooped R handshake, busy
// A hit writes flag=1 plus its data in the accept cycle. A miss writes flag=0 in the
// accept cycle and issues one wrapping 8-beat read burst from the following cycle.
// Flags are written in accept order; AXI returns R bursts in order, so the reorder
// unit can pair each flag=0 with the next returning burst.
module cc_miss_hit_sequencer
   import cc_miss_hit_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned HDATA_W  = CC_HDATA_W,
   parameter int unsigned MAX_OUTS = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   cc_miss_hit_sequencer_if.slave   bus
);

   localparam int unsigned OutsW = $clog2(MAX_OUTS + 1);

   cc_state_e          r_state;
   cc_state_e          w_state_d;
   logic [ADDR_W-1:0]  r_araddr;
   logic [OutsW-1:0]   r_outs_cnt;
   logic [OutsW-1:0]   w_outs_cnt_d;

   logic               w_outs_full;
   logic               w_ready;
   logic               w_accept;
   logic               w_hit_acc;
   logic               w_miss_acc;
   logic               w_r_done;
   logic               w_inc;
   logic               w_dec;
   logic [HDATA_W-1:0] w_hdata;

   assign w_outs_full = (r_outs_cnt >= OutsW'(MAX_OUTS));
   assign w_hdata     = bus.lookup_hdata_i;

   // Gated by rst_n so ready and the FIFO writes are held low while reset is asserted.
   always_comb begin
      w_ready = 1'b0;
      if (rst_n && (r_state == S_IDLE) && !bus.hit_flag_fifo_afull_i) begin
         w_ready = bus.lookup_hit_i ? !bus.hit_data_fifo_afull_i : !w_outs_full;
      end
   end

   assign w_accept   = bus.lookup_valid_i & w_ready;
   assign w_hit_acc  = w_accept & bus.lookup_hit_i;
   assign w_miss_acc = w_accept & ~bus.lookup_hit_i;

   // A completion with nothing outstanding is a protocol error; ignore it so the
   // counter cannot wrap.
   assign w_r_done = bus.mem_rvalid_i & bus.mem_rready_i & bus.mem_rlast_i;
   assign w_inc    = w_miss_acc;
   assign w_dec    = w_r_done & (r_outs_cnt != '0);

   // FSM next state
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         S_IDLE: if (w_miss_acc)        w_state_d = S_AR;
         S_AR:   if (bus.mem_arready_i) w_state_d = S_IDLE;
         default:                       w_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w_outs_cnt_d = r_outs_cnt;
      unique case ({w_inc, w_dec})
         2'b10:   w_outs_cnt_d = r_outs_cnt + OutsW'(1);
         2'b01:   w_outs_cnt_d = r_outs_cnt - OutsW'(1);
         default: w_outs_cnt_d = r_outs_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_outs_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_outs_cnt <= w_outs_cnt_d;
      end
   end

   // Address only loads on a miss accept, which cannot happen in S_AR, so it holds
   // steady until the AR handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_araddr <= '0;
      end else if (w_miss_acc) begin
         r_araddr <= {bus.lookup_addr_i[ADDR_W-1:3], 3'b000};
      end
   end

   assign bus.lookup_ready_o        = w_ready;
   assign bus.hit_flag_fifo_wren_o  = w_accept;
   assign bus.hit_flag_fifo_wdata_o = bus.lookup_hit_i;
   assign bus.hit_data_fifo_wren_o  = w_hit_acc;
   assign bus.hit_data_fifo_wdata_o = w_hdata;

   assign bus.mem_araddr_o  = r_araddr;
   assign bus.mem_arlen_o   = CC_ARLEN;
   assign bus.mem_arsize_o  = CC_ARSIZE;
   assign bus.mem_arburst_o = CC_ARBURST_WRAP;
   assign bus.mem_arvalid_o = (r_state == S_AR);

   assign bus.busy_o = (r_state != S_IDLE) || (r_outs_cnt != '0);

endmodule

// File: tb/tb_cc_miss_hit_sequencer.sv
// Self-checking bench for cc_miss_hit_sequencer: directed scenarios followed by random
// traffic. A transaction-level model predicts ready/arvalid/busy each cycle and pushes
// expected FIFO writes and AR requests into queues; a monitor pops and compares.
module tb_cc_miss_hit_sequencer;
   import cc_miss_hit_sequencer_pkg::*;

   localparam int unsigned AW  = 32;
   localparam int unsigned HW  = CC_HDATA_W;
   localparam int          MAX = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cc_miss_hit_sequencer_if #(.ADDR_W(AW), .HDATA_W(HW)) bus ();

   cc_miss_hit_sequencer #(.ADDR_W(AW), .HDATA_W(HW), .MAX_OUTS(MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: an issued-but-unhandshaken AR request, and bursts not yet completed
   bit m_pend;
   int m_outs;

   bit            exp_flag[$];
   logic [HW-1:0] exp_data[$];
   logic [AW-1:0] exp_ar[$];

   task automatic chk(input string nm, input logic [HW-1:0] got, input logic [HW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [HW-1:0] rand_hdata();
      logic [HW-1:0] d;
      for (int i = 0; i < 17; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // One clock cycle: drive inputs, predict and compare at the falling edge, advance
   // the model at the rising edge.
   task automatic cyc(input bit v, input bit h, input logic [AW-1:0] a, input bit fa,
                      input bit da, input bit ar, input bit rv, input bit rr, input bit rl);
      bit            rdy;
      bit            acc;
      logic [HW-1:0] hd;
      hd = rand_hdata();
      bus.lookup_valid_i        = v;
      bus.lookup_hit_i          = h;
      bus.lookup_addr_i         = a;
      bus.lookup_hdata_i        = hd;
      bus.hit_flag_fifo_afull_i = fa;
      bus.hit_data_fifo_afull_i = da;
      bus.mem_arready_i         = ar;
      bus.mem_rvalid_i          = rv;
      bus.mem_rready_i          = rr;
      bus.mem_rlast_i           = rl;
      @(negedge clk);
      rdy = !m_pend && !fa && (h ? !da : (m_outs < MAX));
      acc = v && rdy;
      chk("lookup_ready", HW'(bus.lookup_ready_o), HW'(rdy));
      chk("arvalid", HW'(bus.mem_arvalid_o), HW'(m_pend));
      chk("busy", HW'(bus.busy_o), HW'(m_pend || (m_outs != 0)));
      if (acc) begin
         exp_flag.push_back(h);
         if (h) exp_data.push_back(hd);
         else   exp_ar.push_back({a[AW-1:3], 3'b000});
      end
      @(posedge clk);
      if (m_pend && ar) m_pend = 1'b0;
      if (acc && !h) begin
         m_pend = 1'b1;
         m_outs++;
      end
      if (rv && rr && rl && (m_outs - ((acc && !h) ? 1 : 0)) > 0) m_outs--;
      #1;
   endtask

   task automatic idle(input bit ar, input bit comp);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, ar, comp, comp, comp);
   endtask

   // Monitor: compares every FIFO write and every AR beat against the queues
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (bus.hit_flag_fifo_wren_o) begin
               if (exp_flag.size() == 0) begin
                  chk("flag_unexpected", HW'(1), HW'(0));
               end else begin
                  chk("flag_wdata", HW'(bus.hit_flag_fifo_wdata_o), HW'(exp_flag.pop_front()));
               end
            end
            if (bus.hit_data_fifo_wren_o) begin
               if (exp_data.size() == 0) begin
                  chk("data_unexpected", HW'(1), HW'(0));
               end else begin
                  chk("data_wdata", bus.hit_data_fifo_wdata_o, exp_data.pop_front());
               end
            end
            if (bus.mem_arvalid_o) begin
               if (exp_ar.size() == 0) begin
                  chk("ar_unexpected", HW'(1), HW'(0));
               end else begin
                  chk("araddr", HW'(bus.mem_araddr_o), HW'(exp_ar[0]));
                  chk("arlen", HW'(bus.mem_arlen_o), HW'(7));
                  chk("arsize", HW'(bus.mem_arsize_o), HW'(3));
                  chk("arburst", HW'(bus.mem_arburst_o), HW'(2));
                  if (bus.mem_arready_i) void'(exp_ar.pop_front());
               end
            end
         end
      end
   end

   initial begin
      bit rv, rr, rl, comp;
      m_pend = 1'b0;
      m_outs = 0;
      rst_n  = 1'b0;
      // A valid hit during reset must not be accepted
      bus.lookup_valid_i        = 1'b1;
      bus.lookup_hit_i          = 1'b1;
      bus.lookup_addr_i         = 32'h1000;
      bus.lookup_hdata_i        = '0;
      bus.hit_flag_fifo_afull_i = 1'b0;
      bus.hit_data_fifo_afull_i = 1'b0;
      bus.mem_arready_i         = 1'b0;
      bus.mem_rvalid_i          = 1'b0;
      bus.mem_rready_i          = 1'b0;
      bus.mem_rlast_i           = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", HW'(bus.lookup_ready_o), HW'(0));
      chk("rst_flag_wren", HW'(bus.hit_flag_fifo_wren_o), HW'(0));
      chk("rst_data_wren", HW'(bus.hit_data_fifo_wren_o), HW'(0));
      chk("rst_arvalid", HW'(bus.mem_arvalid_o), HW'(0));
      chk("rst_araddr", HW'(bus.mem_araddr_o), HW'(0));
      chk("rst_busy", HW'(bus.busy_o), HW'(0));
      bus.lookup_valid_i = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Hit at 0x1000
      cyc(1, 1, 32'h1000, 0, 0, 0, 0, 0, 0);
      // Miss at 0x2034, AR stalled for three cycles while a hit waits
      cyc(1, 0, 32'h2034, 0, 0, 0, 0, 0, 0);
      repeat (3) cyc(1, 1, 32'h3000, 0, 0, 0, 1, 1, 0);
      idle(1, 0);
      // Second miss fills the outstanding budget; third stalls; a hit still flows
      cyc(1, 0, 32'h4008, 0, 0, 0, 0, 0, 0);
      idle(1, 0);
      repeat (2) cyc(1, 0, 32'h5010, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h6000, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 32'h5010, 0, 0, 0, 1, 1, 1);
      cyc(1, 0, 32'h5010, 0, 0, 0, 0, 0, 0);
      idle(1, 0);
      // Completion, then miss accept coinciding with a completion
      idle(0, 1);
      cyc(1, 0, 32'h7038, 0, 0, 0, 1, 1, 1);
      idle(1, 0);
      cyc(1, 0, 32'h8000, 0, 0, 0, 0, 0, 0);
      idle(1, 0);
      cyc(1, 0, 32'h9000, 0, 0, 0, 0, 0, 0);
      idle(0, 1);
      idle(0, 1);
      // Data FIFO almost full blocks hits only
      cyc(1, 1, 32'hA000, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 32'hA018, 0, 1, 0, 0, 0, 0);
      idle(1, 0);
      // Flag FIFO almost full blocks everything
      cyc(1, 1, 32'hA100, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 32'hA108, 1, 0, 0, 0, 0, 0);
      // Spurious completion with nothing outstanding must not wrap the counter
      idle(0, 1);
      idle(0, 1);
      cyc(1, 1, 32'hA200, 0, 0, 0, 0, 0, 0);
      // Reset while in S_AR with two bursts outstanding
      cyc(1, 0, 32'hB000, 0, 0, 0, 0, 0, 0);
      idle(1, 0);
      cyc(1, 0, 32'hC000, 0, 0, 0, 0, 0, 0);
      idle(0, 0);
      chk("pre_rst_outs", HW'(m_outs), HW'(2));
      rst_n = 1'b0;
      #1;
      chk("midrst_arvalid", HW'(bus.mem_arvalid_o), HW'(0));
      chk("midrst_busy", HW'(bus.busy_o), HW'(0));
      chk("midrst_ready", HW'(bus.lookup_ready_o), HW'(0));
      m_pend = 1'b0;
      m_outs = 0;
      exp_flag.delete();
      exp_data.delete();
      exp_ar.delete();
      bus.lookup_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         comp = (m_outs > 0) && ($urandom_range(0, 3) == 0);
         if (comp) begin
            rv = 1; rr = 1; rl = 1;
         end else begin
            rv = 1'($urandom);
            rl = 1'($urandom);
            rr = (rv && rl) ? 1'b0 : 1'($urandom);
         end
         cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0, rv, rr, rl);
      end

      // Drain, bounded
      for (int n = 0; n < 20 && (m_pend || m_outs != 0); n++) idle(1, m_outs > 0);
      chk("drain_model_idle", HW'(m_pend || m_outs != 0), HW'(0));
      chk("drain_busy", HW'(bus.busy_o), HW'(0));
      chk("left_flags", HW'(exp_flag.size()), HW'(0));
      chk("left_data", HW'(exp_data.size()), HW'(0));
      chk("left_ar", HW'(exp_ar.size()), HW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
